frog_ctrl: RTL and testbench

FROG_CTRL -- requirements
Module: frog_ctrl

---
 rtl/frog_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_frog_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_ctrl.sv
// -----------------------------------------------------------------------------
// frog_ctrl
//
// Moves a "frog" sprite around a bounded playfield in response to four
// push-buttons and paces redraw requests to a draw controller at a fixed
// frame rate.
//
// Key presses (rising edges of the synchronised, optionally debounced key
// levels) are held in a one-entry pending-move register.  On each frame tick
// while the draw controller is idle, the pending move is applied to the
// position (clamped to the playfield) and a redraw is requested with go.  go
// stays high until draw_done.  A tick that arrives while a redraw is still
// outstanding sets the sticky overrun flag and leaves position and pending
// move untouched.
//
// Optional build macro: KEY_DEBOUNCE_EN
//   defined   -> each synchronised key must hold a new level for
//                DEBOUNCE_CYCLES consecutive cycles before it is accepted.
//   undefined -> edge detection works directly on the synchroniser output.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   key_up     in   raw button, asynchronous to clk
//   key_down   in   raw button, asynchronous to clk
//   key_left   in   raw button, asynchronous to clk
//   key_right  in   raw button, asynchronous to clk
//   draw_done  in   one-cycle pulse: frame redraw finished
//   go         out  redraw request (level, high until draw_done)
//   frog_x     out  frog column, 0..MAX_X
//   frog_y     out  frog row, 0..MAX_Y
//   overrun    out  sticky: a frame tick hit while a redraw was pending
// -----------------------------------------------------------------------------
module frog_ctrl #(
    parameter int FRAME_DIV       = 833334,
    parameter int STEP            = 10,
    parameter int MAX_X           = 310,
    parameter int MAX_Y           = 230,
    parameter int START_X         = 150,
    parameter int START_Y         = 230,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       draw_done,
    output logic       go,
    output logic [8:0] frog_x,
    output logic [8:0] frog_y,
    output logic       overrun
);

    localparam int CNT_W = $clog2(FRAME_DIV + 1);

    // Move direction encoding used by the pending register.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning: bit 3 = up, 2 = down, 1 = left, 0 = right
    // ------------------------------------------------------------------
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic [3:0] key_level_prev_reg;
    logic [3:0] press;

    assign key_raw = {key_up, key_down, key_left, key_right};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic sync1_reg;
            logic sync2_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

`ifdef KEY_DEBOUNCE_EN
            localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

            logic [DB_W-1:0] db_cnt_reg;
            logic            db_level_reg;

            // Count consecutive cycles the synchronised key disagrees with
            // the accepted level; accept it once it has disagreed for
            // DEBOUNCE_CYCLES cycles in a row.  Any agreement restarts the run.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    db_cnt_reg   <= '0;
                    db_level_reg <= 1'b0;
                end else if (sync2_reg == db_level_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_reg   <= '0;
                    db_level_reg <= sync2_reg;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end

            assign key_level[gi] = db_level_reg;
`else
            assign key_level[gi] = sync2_reg;
`endif

            assign press[gi] = key_level[gi] & ~key_level_prev_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_level_prev_reg <= '0;
        end else begin
            key_level_prev_reg <= key_level;
        end
    end

    // Simultaneous presses resolve up > down > left > right.
    logic       press_any;
    logic [1:0] press_dir;

    assign press_any = |press;

    always_comb begin
        press_dir = DIR_RIGHT;
        if (press[3]) begin
            press_dir = DIR_UP;
        end else if (press[2]) begin
            press_dir = DIR_DOWN;
        end else if (press[1]) begin
            press_dir = DIR_LEFT;
        end
    end

    // ------------------------------------------------------------------
    // Frame tick
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             tick;

    assign tick = (frame_cnt_reg == CNT_W'(FRAME_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (tick) begin
            frame_cnt_reg <= '0;
        end else begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Clamped move arithmetic (10 bits so y + STEP cannot wrap)
    // ------------------------------------------------------------------
    logic       pend_valid_reg, pend_valid_next;
    logic [1:0] pend_dir_reg, pend_dir_next;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [8:0] x_reg, x_next, x_moved;
    logic [8:0] y_reg, y_next, y_moved;
    logic [9:0] x_wide, y_wide, step_w, max_x_w, max_y_w;

    // A press landing on the tick cycle is newer than the pending entry.
    assign move_valid = press_any | pend_valid_reg;
    assign move_dir   = press_any ? press_dir : pend_dir_reg;

    assign x_wide  = {1'b0, x_reg};
    assign y_wide  = {1'b0, y_reg};
    assign step_w  = 10'(STEP);
    assign max_x_w = 10'(MAX_X);
    assign max_y_w = 10'(MAX_Y);

    always_comb begin
        x_moved = x_reg;
        y_moved = y_reg;
        case (move_dir)
            DIR_UP:    y_moved = (y_wide < step_w) ? 9'd0 : 9'(y_wide - step_w);
            DIR_DOWN:  y_moved = (y_wide + step_w > max_y_w) ? 9'(max_y_w) : 9'(y_wide + step_w);
            DIR_LEFT:  x_moved = (x_wide < step_w) ? 9'd0 : 9'(x_wide - step_w);
            default:   x_moved = (x_wide + step_w > max_x_w) ? 9'(max_x_w) : 9'(x_wide + step_w);
        endcase
    end

    // ------------------------------------------------------------------
    // Redraw handshake FSM
    // ------------------------------------------------------------------
    state_t state_reg, state_next;
    logic   overrun_reg, overrun_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            x_reg          <= 9'(START_X);
            y_reg          <= 9'(START_Y);
            pend_valid_reg <= 1'b0;
            pend_dir_reg   <= DIR_UP;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            pend_valid_reg <= pend_valid_next;
            pend_dir_reg   <= pend_dir_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        pend_valid_next = pend_valid_reg;
        pend_dir_next   = pend_dir_reg;
        overrun_next    = overrun_reg;
        go              = 1'b0;

        // Latest press always wins the pending slot.
        if (press_any) begin
            pend_valid_next = 1'b1;
            pend_dir_next   = press_dir;
        end

        case (state_reg)
            S_IDLE: begin
                if (tick) begin
                    if (move_valid) begin
                        x_next = x_moved;
                        y_next = y_moved;
                    end
                    pend_valid_next = 1'b0;
                    state_next      = S_REQ;
                end
            end
            default: begin
                go = 1'b1;
                if (tick) begin
                    overrun_next = 1'b1;
                end
                if (draw_done) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    assign frog_x  = x_reg;
    assign frog_y  = y_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_frog_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_ctrl
//
// Directed bench for frog_ctrl with FRAME_DIV=4, STEP=10, 310x230 playfield,
// start (150,230), DEBOUNCE_CYCLES=3.  A behavioural model works from raw key
// history and the cycle count since reset release; a compare process checks
// go/frog_x/frog_y/overrun against it one time unit after every clock edge.
// Hand-computed literals after each scenario pin the model.  Build with
// KEY_DEBOUNCE_EN defined to exercise the debounced variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frog_ctrl;

    localparam int FRAME_DIV = 4;
    localparam int STEP      = 10;
    localparam int MAX_X     = 310;
    localparam int MAX_Y     = 230;
    localparam int START_X   = 150;
    localparam int START_Y   = 230;
    localparam int DEB       = 3;
    localparam int HIST      = 4096;
`ifdef KEY_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       draw_done = 1'b0;
    logic       go;
    logic [8:0] frog_x, frog_y;
    logic       overrun;

    always #5 clk = ~clk;

    frog_ctrl #(
        .FRAME_DIV(FRAME_DIV), .STEP(STEP), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
        .START_X(START_X), .START_Y(START_Y), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .draw_done(draw_done), .go(go), .frog_x(frog_x), .frog_y(frog_y), .overrun(overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_x, m_y, m_pd, n;
    bit  m_go, m_ovr, m_pv;
    logic [3:0] raw_hist [0:HIST-1];
    logic [3:0] lvl_hist [0:HIST-1];

    // Edge 1 is the first clock edge after reset release; earlier = idle.
    function automatic logic [3:0] raw_at(input int k);
        if (k < 1) return 4'b0;
        return raw_hist[k];
    endfunction

    function automatic logic [3:0] lvl_at(input int k);
        if (k < 1) return 4'b0;
        return lvl_hist[k];
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_go = 0; m_ovr = 0; m_pv = 0; m_pd = 0; n = 0;
    endtask

    task automatic do_move(input int d);
        case (d)
            0: m_y = (m_y < STEP) ? 0 : m_y - STEP;
            1: m_y = (m_y + STEP > MAX_Y) ? MAX_Y : m_y + STEP;
            2: m_x = (m_x < STEP) ? 0 : m_x - STEP;
            default: m_x = (m_x + STEP > MAX_X) ? MAX_X : m_x + STEP;
        endcase
    endtask

    task automatic model_step();
        logic [3:0] lvl, prev1, prev2, press, r;
        int  pdir, d;
        bit  cur, flip, tick;
        n++;
        if (n >= HIST) begin
            $display("FAIL model_history: got %0d expected below %0d", n, HIST);
            $fatal(1, "history overflow");
        end
        raw_hist[n] = {key_up, key_down, key_left, key_right};
        prev1 = lvl_at(n - 1);
        for (int b = 0; b < 4; b++) begin
            if (DB_ON) begin
                // Level flips once the last DEB synchronised samples
                // (raw samples two edges back) all show the other value.
                cur  = prev1[b];
                flip = 1'b1;
                for (int j = n - DEB - 1; j <= n - 2; j++) begin
                    r = raw_at(j);
                    if (r[b] == cur) flip = 1'b0;
                end
                lvl[b] = flip ? ~cur : cur;
            end else begin
                r = raw_at(n - 1);
                lvl[b] = r[b];
            end
        end
        lvl_hist[n] = lvl;
        prev2 = lvl_at(n - 2);
        press = prev1 & ~prev2;
        pdir = press[3] ? 0 : press[2] ? 1 : press[1] ? 2 : press[0] ? 3 : -1;
        tick = ((n % FRAME_DIV) == 0);
        if (!m_go) begin
            if (tick) begin
                d = (pdir >= 0) ? pdir : (m_pv ? m_pd : -1);
                if (d >= 0) do_move(d);
                m_pv = 0;
                m_go = 1;
            end else if (pdir >= 0) begin
                m_pv = 1; m_pd = pdir;
            end
        end else begin
            if (pdir >= 0) begin
                m_pv = 1; m_pd = pdir;
            end
            if (tick) m_ovr = 1;
            if (draw_done) m_go = 0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        if (!reset) model_step();
        #1;
        check("go", go, m_go);
        check("frog_x", frog_x, m_x);
        check("frog_y", frog_y, m_y);
        check("overrun", overrun, m_ovr);
    end

    // ---------------- stimulus helpers ----------------
    bit auto_ack = 0;

    // One cycle: drive keys {up,down,left,right}; ack any raised go.
    task automatic cyc(input logic [3:0] k);
        @(negedge clk);
        {key_up, key_down, key_left, key_right} = k;
        draw_done = auto_ack && go;
    endtask

    task automatic idle(input int c);
        repeat (c) cyc(4'b0000);
    endtask

    task automatic press_key(input logic [3:0] k, input int hold);
        repeat (hold) cyc(k);
        idle(8);
    endtask

    task automatic wait_go();
        for (int i = 0; i < 12 && !go; i++) cyc(4'b0000);
        check("wait_go", go, 1);
    endtask

    task automatic release_and_time_go(input string name);
        int rise_at;
        rise_at = -1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 8 && rise_at < 0; i++) begin
            @(posedge clk);
            #1;
            if (go) rise_at = i;
        end
        check(name, rise_at, FRAME_DIV);
    endtask

    initial begin
        model_reset();
        idle(3);
        check("rst_go", go, 0);
        check("rst_x", frog_x, 150);
        check("rst_y", frog_y, 230);
        check("rst_ovr", overrun, 0);

        // Reset release: go rises after 4 edges, drops right after draw_done.
        release_and_time_go("go_rise_cycle");
        @(negedge clk);
        draw_done = 1'b1;
        @(posedge clk);
        #1;
        check("go_after_done", go, 0);
        @(negedge clk);
        draw_done = 1'b0;
        check("idle_x", frog_x, 150);
        check("idle_y", frog_y, 230);
        auto_ack = 1;

        // Down at the bottom border stays put.
        press_key(4'b0100, 6);
        check("down_clamp_y", frog_y, 230);

        // Up moves by one step.
        press_key(4'b1000, 6);
        check("up_y", frog_y, 220);
        check("up_x", frog_x, 150);

        // Up and left together: up wins.
        press_key(4'b1010, 6);
        check("prio_y", frog_y, 210);
        check("prio_x", frog_x, 150);

        // 16 lefts from x=150 bottom out at 0.
        for (int i = 0; i < 16; i++) press_key(4'b0010, 6);
        check("left_clamp_x", frog_x, 0);
        check("no_ovr_yet", overrun, 0);

        // Withhold draw_done over two ticks with a right press pending.
        auto_ack = 0;
        wait_go();
        repeat (6) cyc(4'b0001);
        idle(6);
        check("ovr_set", overrun, 1);
        check("ovr_go_held", go, 1);
        check("ovr_x_held", frog_x, 0);
        auto_ack = 1;
        idle(10);
        check("right_after_ack_x", frog_x, 10);
        check("ovr_sticky", overrun, 1);

        // Two-cycle glitch: ignored only when debounced.
        repeat (2) cyc(4'b0001);
        idle(12);
        check("glitch_x", frog_x, DB_ON ? 10 : 20);
        // Five-cycle press: exactly one move.
        press_key(4'b0001, 5);
        check("press5_x", frog_x, DB_ON ? 20 : 30);

        // Reset in the middle of a request.
        auto_ack = 0;
        wait_go();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_go", go, 0);
        check("midrst_x", frog_x, 150);
        check("midrst_y", frog_y, 230);
        check("midrst_ovr", overrun, 0);
        idle(2);
        release_and_time_go("go_rise_after_midrst");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
